break_min_selector: RTL and testbench
=====================================

BREAK_MIN_SELECTOR -- requirements
Module: break_min_selector

Interface
REQ-001 The block SHALL have parameter NUM_CLAUSES, default 20, meaning clause count per break-value evaluation; BV_BITS = $clog2(NUM_CLAUSES) is derived from it.
REQ-002 The block SHALL have parameter NUM_LITS, default 3, meaning literals per clause, i.e. candidates per selection.
REQ-003 The block SHALL have parameter VAR_BITS, default 8, meaning variable index width.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start_i, input, 1 bit: request a selection; sampled only in IDLE.
REQ-007 Port lit_vars_i, input, NUM_LITS*VAR_BITS: candidate variable indices; slot k is bits [k*VAR_BITS +: VAR_BITS]; captured when start_i is accepted.
REQ-008 Port noise_thresh_i, input, 8 bits: random-walk probability threshold, where 0 means never and 255 means 255/256.
REQ-009 Port bv_req_o, output, 1 bit: break value requested for cand_var_o.
REQ-010 Port cand_var_o, output, VAR_BITS: variable currently being evaluated.
REQ-011 Port bv_valid_i, input, 1 bit: break_value_i is valid for cand_var_o.
REQ-012 Port break_value_i, input, BV_BITS: masked broken-clause count from the break value counter.
REQ-013 Port sel_valid_o, output, 1 bit: selection result available.
REQ-014 Port sel_var_o, output, VAR_BITS: selected variable to flip.
REQ-015 Port sel_random_o, output, 1 bit: selection was made by the random-walk path.
REQ-016 Port sel_ready_i, input, 1 bit: consumer accepts the selection.
REQ-017 Port busy_o, output, 1 bit: asserted in every state other than IDLE.

Function
REQ-018 The block SHALL implement the states IDLE, EVAL, DECIDE and DONE, with a candidate index k in the range 0..NUM_LITS-1.
REQ-019 IDLE: when start_i=1, the block SHALL capture lit_vars_i, set k=0, set best_bv to all-ones and best_k=0, then enter EVAL; start_i in any other state SHALL be ignored.
REQ-020 EVAL: the block SHALL drive bv_req_o=1 and cand_var_o=lit[k], holding both stable until bv_valid_i=1; a response in the same cycle as the request is legal.
REQ-021 On bv_valid_i in EVAL, if break_value_i < best_bv (strict), the block SHALL update best_bv and best_k; ties SHALL keep the lower k.
REQ-022 On bv_valid_i with break_value_i==0 (freebie), the block SHALL select lit[k], set sel_random_o=0 and go directly to DONE, skipping the remaining candidates and DECIDE.
REQ-023 On bv_valid_i with k==NUM_LITS-1 and no freebie, the block SHALL go to DECIDE; otherwise it SHALL increment k and stay in EVAL.
REQ-024 DECIDE (one cycle): if lfsr[7:0] < noise_thresh_i, the block SHALL select lit[lfsr[15:8] mod NUM_LITS] with sel_random_o=1; otherwise it SHALL select lit[best_k] with sel_random_o=0; it SHALL then go to DONE.
REQ-025 DONE: the block SHALL hold sel_valid_o=1 with sel_var_o and sel_random_o stable until sel_ready_i=1, then go to IDLE; start_i in that same cycle SHALL be ignored.
REQ-026 The block SHALL contain a 16-bit Fibonacci LFSR with taps 16,14,13,11, which SHALL advance every cycle independent of state.
REQ-027 With bv_valid_i tied high, start accepted at edge 0 SHALL give sel_valid_o=1 after edge NUM_LITS+2 (non-freebie) or after edge k+2 (freebie at candidate k).
REQ-028 bv_req_o and sel_valid_o SHALL be registered outputs and SHALL never both be 1.
REQ-029 break_value_i SHALL be treated as unsigned; a value of all-ones SHALL still update best for k=0 because best_bv is initialised to all-ones and best_k=0.

Reset
REQ-030 While reset=0, the block SHALL force state=IDLE, k=0, best_bv=all-ones, best_k=0 and lfsr=16'hACE1.
REQ-031 While reset=0, the block SHALL drive bv_req_o=0, cand_var_o=0, sel_valid_o=0, sel_var_o=0, sel_random_o=0 and busy_o=0.
REQ-032 Reset asserted mid-EVAL or mid-DONE SHALL abort the selection with no output handshake; the first start_i after release SHALL begin a fresh selection.

Verification
REQ-033 Greedy path: noise_thresh=0, lits {5,9,12}, bv {4,2,2}, bv_valid tied 1 -> sel_var=9, sel_random=0, sel_valid after edge 5.
REQ-034 Freebie path: lits {5,9,12}, bv {3,0,x} -> only 2 bv_req cycles, sel_var=9, no request ever shows cand_var=12.
REQ-035 Random walk: noise_thresh=255 with the LFSR forced so lfsr[7:0]=0x10 and lfsr[15:8]=0x07 -> sel_var=lit[1], sel_random=1.
REQ-036 Backpressure: bv_valid delayed 3 cycles per candidate and sel_ready held 0 for 4 cycles -> cand_var and sel_var stable, one selection, busy_o high throughout; start_i pulsed mid-run is ignored.
REQ-037 Reset mid-EVAL at k=1 -> all outputs return to their reset values immediately; next start with bv {1,1,1} -> sel_var=lit[0].
REQ-038 Back-to-back: sel_ready and start_i high in the same cycle -> start ignored; start the next cycle is accepted.

Source files
------------

// File: rtl/break_min_selector_if.sv
// break_min_selector_if
//
// Bundles the selection request, the break-value query/response pair and
// the selection result handshake of break_min_selector.
//
// Signals (directions seen from the selector, i.e. the slave modport):
//   start_i        in  : request a new selection
//   lit_vars_i     in  : NUM_LITS packed candidate variable indices
//   noise_thresh_i in  : random-walk probability threshold (x/256)
//   bv_req_o       out : break value requested for cand_var_o
//   cand_var_o     out : variable currently being evaluated
//   bv_valid_i     in  : break_value_i is valid for cand_var_o
//   break_value_i  in  : broken-clause count for cand_var_o
//   sel_valid_o    out : selection result available
//   sel_var_o      out : selected variable to flip
//   sel_random_o   out : selection came from the random-walk path
//   sel_ready_i    in  : consumer accepts the selection
//   busy_o         out : selector is not idle
//
// The master modport is the mirror image, used by whatever drives the
// selector (solver control plus the break value counter).

interface break_min_selector_if #(
    parameter int NUM_CLAUSES = 20,
    parameter int NUM_LITS    = 3,
    parameter int VAR_BITS    = 8
);
    localparam int BV_BITS = $clog2(NUM_CLAUSES);

    logic                         start_i;
    logic [NUM_LITS*VAR_BITS-1:0] lit_vars_i;
    logic [7:0]                   noise_thresh_i;
    logic                         bv_req_o;
    logic [VAR_BITS-1:0]          cand_var_o;
    logic                         bv_valid_i;
    logic [BV_BITS-1:0]           break_value_i;
    logic                         sel_valid_o;
    logic [VAR_BITS-1:0]          sel_var_o;
    logic                         sel_random_o;
    logic                         sel_ready_i;
    logic                         busy_o;

    modport slave (
        input  start_i,
        input  lit_vars_i,
        input  noise_thresh_i,
        output bv_req_o,
        output cand_var_o,
        input  bv_valid_i,
        input  break_value_i,
        output sel_valid_o,
        output sel_var_o,
        output sel_random_o,
        input  sel_ready_i,
        output busy_o
    );

    modport master (
        output start_i,
        output lit_vars_i,
        output noise_thresh_i,
        input  bv_req_o,
        input  cand_var_o,
        output bv_valid_i,
        output break_value_i,
        input  sel_valid_o,
        input  sel_var_o,
        input  sel_random_o,
        output sel_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/break_min_selector.sv
// break_min_selector
//
// WalkSAT-style flip variable selector. For one unsatisfied clause it asks
// the break value counter for the break value of every literal's variable in
// turn, tracks the lowest one (ties keep the earliest literal), and then
// either takes that minimum or, with probability noise_thresh/256, a random
// literal. A literal with break value zero ("freebie") is taken immediately.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous, active-low reset
//   bus    : break_min_selector_if.slave carrying the start request, the
//            break-value query/response and the selection result handshake

module break_min_selector #(
    parameter int NUM_CLAUSES = 20,
    parameter int NUM_LITS    = 3,
    parameter int VAR_BITS    = 8
) (
    input logic                clk,
    input logic                reset,
    break_min_selector_if.slave bus
);
    localparam int BV_BITS = $clog2(NUM_CLAUSES);
    localparam int K_BITS  = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1;

    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(NUM_LITS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]                   state_q,      state_d;
    logic [K_BITS-1:0]            k_q,          k_d;
    logic [BV_BITS-1:0]           best_bv_q,    best_bv_d;
    logic [K_BITS-1:0]            best_k_q,     best_k_d;
    logic [NUM_LITS*VAR_BITS-1:0] lits_q,       lits_d;
    logic [15:0]                  lfsr_q,       lfsr_d;
    logic                         bv_req_q,     bv_req_d;
    logic [VAR_BITS-1:0]          cand_var_q,   cand_var_d;
    logic                         sel_valid_q,  sel_valid_d;
    logic [VAR_BITS-1:0]          sel_var_q,    sel_var_d;
    logic                         sel_random_q, sel_random_d;

    logic              bv_fire;
    logic              sel_fire;
    logic [K_BITS-1:0] rand_k;

    function automatic logic [VAR_BITS-1:0] lit_at(
        input logic [NUM_LITS*VAR_BITS-1:0] lits,
        input logic [K_BITS-1:0]            idx
    );
        return lits[int'(idx)*VAR_BITS +: VAR_BITS];
    endfunction

    // bv_req_o is high exactly while in EVAL, so a valid response in EVAL is
    // always a completed query.
    assign bv_fire  = (state_q == S_EVAL) && bus.bv_valid_i;
    assign sel_fire = sel_valid_q && bus.sel_ready_i;

    // Random-walk candidate index from the upper LFSR byte.
    assign rand_k = K_BITS'(32'(lfsr_q[15:8]) % NUM_LITS);

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        best_bv_d    = best_bv_q;
        best_k_d     = best_k_q;
        lits_d       = lits_q;
        sel_var_d    = sel_var_q;
        sel_random_d = sel_random_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    lits_d    = bus.lit_vars_i;
                    k_d       = '0;
                    best_bv_d = '1;
                    best_k_d  = '0;
                    state_d   = S_EVAL;
                end
            end

            S_EVAL: begin
                if (bv_fire) begin
                    // Strict compare so a tie keeps the earlier literal; the
                    // all-ones start value still loses to an all-ones reply
                    // only by keeping best_k=0, which is the same result.
                    if (bus.break_value_i < best_bv_q) begin
                        best_bv_d = bus.break_value_i;
                        best_k_d  = k_q;
                    end
                    if (bus.break_value_i == '0) begin
                        sel_var_d    = lit_at(lits_q, k_q);
                        sel_random_d = 1'b0;
                        state_d      = S_DONE;
                    end else if (k_q == K_LAST) begin
                        state_d = S_DECIDE;
                    end else begin
                        k_d = k_q + K_BITS'(1);
                    end
                end
            end

            S_DECIDE: begin
                if (lfsr_q[7:0] < bus.noise_thresh_i) begin
                    sel_var_d    = lit_at(lits_q, rand_k);
                    sel_random_d = 1'b1;
                end else begin
                    sel_var_d    = lit_at(lits_q, best_k_q);
                    sel_random_d = 1'b0;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (sel_fire) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs. The query side follows the next state so the
    // request appears together with EVAL. sel_valid is registered off the
    // current state instead, so the result is offered one cycle after DONE
    // is entered, once sel_var/sel_random have settled; since it is only
    // ever set while already in DONE it can never overlap bv_req.
    always_comb begin
        bv_req_d    = (state_d == S_EVAL);
        cand_var_d  = (state_d == S_EVAL) ? lit_at(lits_d, k_d) : '0;
        sel_valid_d = (state_q == S_DONE) && !sel_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            best_bv_q    <= '1;
            best_k_q     <= '0;
            lits_q       <= '0;
            lfsr_q       <= 16'hACE1;
            bv_req_q     <= 1'b0;
            cand_var_q   <= '0;
            sel_valid_q  <= 1'b0;
            sel_var_q    <= '0;
            sel_random_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            best_bv_q    <= best_bv_d;
            best_k_q     <= best_k_d;
            lits_q       <= lits_d;
            lfsr_q       <= lfsr_d;
            bv_req_q     <= bv_req_d;
            cand_var_q   <= cand_var_d;
            sel_valid_q  <= sel_valid_d;
            sel_var_q    <= sel_var_d;
            sel_random_q <= sel_random_d;
        end
    end

    assign bus.bv_req_o     = bv_req_q;
    assign bus.cand_var_o   = cand_var_q;
    assign bus.sel_valid_o  = sel_valid_q;
    assign bus.sel_var_o    = sel_var_q;
    assign bus.sel_random_o = sel_random_q;
    assign bus.busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_break_min_selector.sv
// tb_break_min_selector
//
// Self-checking bench for break_min_selector. The bench plays the role of
// both the solver control and the break value counter, and predicts every
// selection from the candidate list, the break values and the LFSR value.

module tb_break_min_selector;
    localparam int NUM_CLAUSES = 20;
    localparam int NUM_LITS    = 3;
    localparam int VAR_BITS    = 8;
    localparam int BV_BITS     = $clog2(NUM_CLAUSES);

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    int edge_count = 0;

    logic [15:0] model_lfsr;

    break_min_selector_if #(
        .NUM_CLAUSES(NUM_CLAUSES),
        .NUM_LITS   (NUM_LITS),
        .VAR_BITS   (VAR_BITS)
    ) bus ();

    break_min_selector #(
        .NUM_CLAUSES(NUM_CLAUSES),
        .NUM_LITS   (NUM_LITS),
        .VAR_BITS   (VAR_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // One step of the x^16 + x^14 + x^13 + x^11 + 1 sequence.
    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_lfsr <= 16'hACE1;
        else        model_lfsr <= lfsrStep(model_lfsr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_count++;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_bv_req"},     32'(bus.bv_req_o),     0);
        checkOutput({tag, "_cand_var"},   32'(bus.cand_var_o),   0);
        checkOutput({tag, "_sel_valid"},  32'(bus.sel_valid_o),  0);
        checkOutput({tag, "_sel_var"},    32'(bus.sel_var_o),    0);
        checkOutput({tag, "_sel_random"}, 32'(bus.sel_random_o), 0);
        checkOutput({tag, "_busy"},       32'(bus.busy_o),       0);
    endtask

    // Runs one full selection and checks it against the reference rules.
    // Called at posedge+1 with the selector idle.
    task automatic applyStimulus(
        input logic [NUM_LITS*VAR_BITS-1:0] lits_p,
        input logic [NUM_LITS*BV_BITS-1:0]  bvs_p,
        input logic [7:0]                   thresh,
        input int                           min_delay,
        input int                           max_delay,
        input int                           ready_delay,
        input bit                           poke_start
    );
        int lit [NUM_LITS];
        int bv  [NUM_LITS];
        int freebie_k;
        int best_k;
        int n_eval;
        int delay_sum;
        int start_edge;
        int last_edge;
        int waited;
        int exp_var;
        int exp_rnd;
        logic [15:0] decide_lfsr;

        for (int i = 0; i < NUM_LITS; i++) begin
            lit[i] = int'(lits_p[i*VAR_BITS +: VAR_BITS]);
            bv[i]  = int'(bvs_p[i*BV_BITS +: BV_BITS]);
        end

        // Reference: first zero wins outright, else lowest value, earliest on ties.
        freebie_k = -1;
        for (int i = 0; i < NUM_LITS; i++)
            if (freebie_k < 0 && bv[i] == 0) freebie_k = i;
        best_k = 0;
        for (int i = 1; i < NUM_LITS; i++)
            if (bv[i] < bv[best_k]) best_k = i;
        n_eval = (freebie_k >= 0) ? freebie_k + 1 : NUM_LITS;

        bus.start_i        = 1'b1;
        bus.lit_vars_i     = lits_p;
        bus.noise_thresh_i = thresh;
        tick();
        start_edge         = edge_count;
        bus.start_i        = 1'b0;
        bus.lit_vars_i     = NUM_LITS*VAR_BITS'($urandom);
        checkOutput("busy_after_start", 32'(bus.busy_o), 1);

        delay_sum = 0;
        for (int k = 0; k < n_eval; k++) begin
            int d;
            d = int'($urandom_range(max_delay, min_delay));
            delay_sum += d;
            for (int c = 0; c < d; c++) begin
                checkOutput("bv_req_hold",   32'(bus.bv_req_o),    1);
                checkOutput("cand_var_hold", 32'(bus.cand_var_o),  lit[k]);
                checkOutput("busy_eval",     32'(bus.busy_o),      1);
                checkOutput("no_sel_eval",   32'(bus.sel_valid_o), 0);
                if (poke_start && c == 0) bus.start_i = 1'b1;
                tick();
                bus.start_i = 1'b0;
            end
            checkOutput("bv_req",   32'(bus.bv_req_o),   1);
            checkOutput("cand_var", 32'(bus.cand_var_o), lit[k]);
            bus.bv_valid_i    = 1'b1;
            bus.break_value_i = BV_BITS'(bv[k]);
            tick();
            bus.bv_valid_i    = 1'b0;
            bus.break_value_i = BV_BITS'($urandom);
        end
        last_edge   = edge_count;
        decide_lfsr = model_lfsr;

        if (freebie_k >= 0) begin
            exp_var = lit[freebie_k];
            exp_rnd = 0;
        end else if (decide_lfsr[7:0] < thresh) begin
            exp_var = lit[int'(decide_lfsr[15:8]) % NUM_LITS];
            exp_rnd = 1;
        end else begin
            exp_var = lit[best_k];
            exp_rnd = 0;
        end

        waited = 0;
        while (bus.sel_valid_o !== 1'b1 && waited < 10) begin
            checkOutput("no_req_after_eval", 32'(bus.bv_req_o), 0);
            checkOutput("busy_decide",       32'(bus.busy_o),   1);
            tick();
            waited++;
        end
        checkOutput("sel_valid_seen", 32'(bus.sel_valid_o), 1);
        checkOutput("valid_latency",  32'(edge_count - last_edge), (freebie_k >= 0) ? 1 : 2);
        checkOutput("start_to_valid", 32'(edge_count - start_edge),
                    32'(delay_sum + n_eval + ((freebie_k >= 0) ? 1 : 2)));
        checkOutput("sel_var",        32'(bus.sel_var_o),    exp_var);
        checkOutput("sel_random",     32'(bus.sel_random_o), exp_rnd);
        checkOutput("req_vs_valid",   32'(bus.bv_req_o),     0);

        for (int r = 0; r < ready_delay; r++) begin
            if (poke_start && r == 0) bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            checkOutput("sel_valid_hold",  32'(bus.sel_valid_o),  1);
            checkOutput("sel_var_hold",    32'(bus.sel_var_o),    exp_var);
            checkOutput("sel_random_hold", 32'(bus.sel_random_o), exp_rnd);
            checkOutput("busy_done",       32'(bus.busy_o),       1);
        end

        // Acknowledge; a start in the same cycle must be ignored.
        bus.sel_ready_i = 1'b1;
        bus.start_i     = poke_start;
        tick();
        bus.sel_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        checkOutput("valid_dropped", 32'(bus.sel_valid_o), 0);
        checkOutput("idle_after_ack", 32'(bus.busy_o),     0);
        checkOutput("no_req_after_ack", 32'(bus.bv_req_o), 0);
    endtask

    // Abort a selection with reset, either in EVAL at k=1 or while in DONE.
    task automatic resetMidRun(input logic [NUM_LITS*VAR_BITS-1:0] lits_p, input bit in_done);
        int waited;
        bus.start_i        = 1'b1;
        bus.lit_vars_i     = lits_p;
        bus.noise_thresh_i = 8'd0;
        tick();
        bus.start_i        = 1'b0;
        bus.bv_valid_i     = 1'b1;
        bus.break_value_i  = in_done ? BV_BITS'(0) : BV_BITS'(5);
        tick();
        bus.bv_valid_i     = 1'b0;
        if (in_done) begin
            waited = 0;
            while (bus.sel_valid_o !== 1'b1 && waited < 5) begin
                tick();
                waited++;
            end
            checkOutput("pre_reset_valid", 32'(bus.sel_valid_o), 1);
        end else begin
            checkOutput("pre_reset_cand", 32'(bus.cand_var_o), 32'(lits_p[VAR_BITS +: VAR_BITS]));
        end
        #2;
        reset = 1'b0;
        #1;
        checkResetOutputs(in_done ? "rst_done" : "rst_eval");
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("idle_after_release", 32'(bus.busy_o), 0);
    endtask

    initial begin
        logic [NUM_LITS*VAR_BITS-1:0] lits_p;
        logic [NUM_LITS*BV_BITS-1:0]  bvs_p;
        logic [7:0]                   thresh;

        reset              = 1'b0;
        bus.start_i        = 1'b0;
        bus.lit_vars_i     = '0;
        bus.noise_thresh_i = '0;
        bus.bv_valid_i     = 1'b0;
        bus.break_value_i  = '0;
        bus.sel_ready_i    = 1'b0;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("idle_after_reset", 32'(bus.busy_o), 0);

        // Greedy: lits {5,9,12}, bv {4,2,2}, responses immediate -> 9.
        lits_p = {8'd12, 8'd9, 8'd5};
        bvs_p  = {5'd2, 5'd2, 5'd4};
        applyStimulus(lits_p, bvs_p, 8'd0, 0, 0, 0, 1'b0);

        // Freebie at k=1: bv {3,0,x} -> 9 and candidate 12 never requested.
        bvs_p = {5'd7, 5'd0, 5'd3};
        applyStimulus(lits_p, bvs_p, 8'd0, 0, 0, 1, 1'b0);

        // Random walk with maximum noise.
        bvs_p = {5'd6, 5'd3, 5'd8};
        applyStimulus(lits_p, bvs_p, 8'd255, 0, 0, 0, 1'b0);

        // Backpressure with stray start pulses mid-run and at the ack.
        lits_p = {8'd77, 8'd200, 8'd31};
        bvs_p  = {5'd4, 5'd9, 5'd4};
        applyStimulus(lits_p, bvs_p, 8'd0, 3, 3, 4, 1'b1);

        // All-ones break values still select literal 0.
        bvs_p = '1;
        applyStimulus(lits_p, bvs_p, 8'd0, 0, 1, 0, 1'b0);

        // Reset aborts, then a fresh selection with bv {1,1,1} picks lit[0].
        resetMidRun(lits_p, 1'b0);
        applyStimulus(lits_p, {5'd1, 5'd1, 5'd1}, 8'd0, 0, 0, 0, 1'b0);
        resetMidRun(lits_p, 1'b1);
        applyStimulus(lits_p, {5'd1, 5'd1, 5'd1}, 8'd0, 0, 2, 1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            lits_p = NUM_LITS*VAR_BITS'($urandom);
            for (int i = 0; i < NUM_LITS; i++)
                bvs_p[i*BV_BITS +: BV_BITS] = ($urandom_range(3, 0) == 0) ? BV_BITS'(0)
                                                                          : BV_BITS'($urandom_range(31, 1));
            case ($urandom_range(3, 0))
                0:       thresh = 8'd0;
                1:       thresh = 8'd128;
                2:       thresh = 8'd255;
                default: thresh = 8'($urandom);
            endcase
            applyStimulus(lits_p, bvs_p, thresh, 0, int'($urandom_range(3, 0)),
                          int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
